// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and default geometry for piso_ctrl
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam int NIB_W_DEF = 4;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/piso_rr_arb.sv
// rtl/piso_rr_arb.sv - two-requester round-robin grant, favours the requester not granted last
module piso_rr_arb (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req_valid;
    if (&req_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid[1];
    end
  end

endmodule

// File: rtl/piso_ctrl.sv
// rtl/piso_ctrl.sv - two-requester word-to-nibble serializer with round-robin word selection
module piso_ctrl
  import piso_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [NIB_W*DEPTH-1:0] req_data0,
  input  logic [NIB_W*DEPTH-1:0] req_data1,
  output logic [1:0]             req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W-1:0]       out_data,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   out_id,
  output logic                   busy
);

  localparam int W     = NIB_W * DEPTH;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  piso_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     word_q, word_d;
  logic             out_id_q, out_id_d;
  logic             last_grant_q, last_grant_d;

  logic grant;
  logic grant_valid;
  logic fire;
  logic load;

  piso_rr_arb u_arb (
    .req_valid   (req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign fire = (state_q == SHIFT) && out_ready;
  // A new word may enter while idle or on the handshake of the final nibble.
  assign load = (state_q == IDLE) || (fire && (cnt_q == CNT_LAST));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    req_ready    = 2'b00;
    if (load) begin
      if (grant_valid) begin
        req_ready    = grant ? 2'b10 : 2'b01;
        word_d       = grant ? req_data1 : req_data0;
        cnt_d        = '0;
        out_id_d     = grant;
        last_grant_d = grant;
        state_d      = SHIFT;
      end else begin
        word_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else if (fire) begin
      word_d = word_q >> NIB_W;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      out_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign out_data  = word_q[NIB_W-1:0];
  assign out_first = (state_q == SHIFT) && (cnt_q == '0);
  assign out_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_piso_ctrl.sv
// tb/tb_piso_ctrl.sv - directed self-checking bench for piso_ctrl
module tb_piso_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data0;
  logic [15:0] req_data1;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_first;
  logic        out_last;
  logic        out_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  piso_ctrl #(.NIB_W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    next_cycle();
    reset     = 1'b0;
    req_valid = 2'b00;
    out_ready = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic check_nibble(input string tag, input logic [3:0] exp_data, input logic exp_id,
                              input logic exp_first, input logic exp_last);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"},  {28'd0, out_data},  {28'd0, exp_data});
    check_eq({tag, "_id"},    {31'd0, out_id},    {31'd0, exp_id});
    check_eq({tag, "_first"}, {31'd0, out_first}, {31'd0, exp_first});
    check_eq({tag, "_last"},  {31'd0, out_last},  {31'd0, exp_last});
  endtask

  // Protocol monitor: ready one-hot-or-zero, only under load, data held while stalled.
  logic       prev_hold = 1'b0;
  logic [3:0] prev_data = 4'd0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check_eq("mon_rdy_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
      if (req_ready != 2'b00)
        check_eq("mon_rdy_load", {31'd0, (!out_valid) || (out_last && out_ready)}, 32'd1);
      if (prev_hold)
        check_eq("mon_hold_data", {28'd0, out_data}, {28'd0, prev_data});
    end
    prev_hold = reset && out_valid && !out_ready;
    prev_data = out_data;
  end

  int         rdy_v[7] = '{1, 0, 0, 0, 1, 1, 1};
  logic [3:0] exp_v[7] = '{4'h5, 4'h6, 4'h6, 4'h6, 4'h6, 4'h7, 4'h8};

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    req_data0 = 16'h0;
    req_data1 = 16'h0;
    out_ready = 1'b1;

    // Reset values, then a single word from requester 0.
    do_reset();
    #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy},      32'd0);
    check_eq("rst_first", {31'd0, out_first}, 32'd0);
    check_eq("rst_last",  {31'd0, out_last},  32'd0);
    check_eq("rst_data",  {28'd0, out_data},  32'd0);
    check_eq("rst_ready", {30'd0, req_ready}, 32'd0);
    next_cycle();
    req_valid = 2'b01;
    req_data0 = 16'h4321;
    #1;
    check_eq("w1_grant", {30'd0, req_ready}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      next_cycle();
      req_valid = 2'b00;
      req_data0 = 16'hFFFF;
      #1;
      check_nibble("w1", 4'(n + 1), 1'b0, n == 0, n == 3);
      check_eq("w1_busy", {31'd0, busy}, 32'd1);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      #1;
      check_eq("w1_idle_valid", {31'd0, out_valid}, 32'd0);
      check_eq("w1_idle_busy",  {31'd0, busy},      32'd0);
    end

    // Both requesters always valid: words alternate 0,1,0,1 with no gap.
    do_reset();
    req_valid = 2'b11;
    req_data0 = 16'hAAAA;
    req_data1 = 16'h5555;
    #1;
    check_eq("rr_grant0", {30'd0, req_ready}, 32'd1);
    for (int w = 0; w < 4; w++) begin
      for (int n = 0; n < 4; n++) begin
        next_cycle();
        #1;
        check_nibble("rr", (w % 2 == 1) ? 4'h5 : 4'hA, w % 2 == 1, n == 0, n == 3);
        check_eq("rr_ready", {30'd0, req_ready},
                 (n == 3) ? ((w % 2 == 1) ? 32'd1 : 32'd2) : 32'd0);
      end
    end

    // Downstream stall on the second nibble.
    do_reset();
    req_valid = 2'b01;
    req_data0 = 16'h8765;
    #1;
    check_eq("st_grant", {30'd0, req_ready}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      req_valid = 2'b00;
      out_ready = (rdy_v[i] != 0);
      #1;
      check_nibble("st", exp_v[i], 1'b0, i == 0, i == 6);
    end
    next_cycle();
    out_ready = 1'b1;
    #1;
    check_eq("st_end_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a word discards it.
    do_reset();
    req_valid = 2'b01;
    req_data0 = 16'hFEDC;
    #1;
    check_eq("mr_grant", {30'd0, req_ready}, 32'd1);
    for (int n = 0; n < 3; n++) begin
      next_cycle();
      req_valid = 2'b00;
      #1;
      check_nibble("mr", 4'(4'hC + n), 1'b0, n == 0, 1'b0);
    end
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    check_eq("mr_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mr_busy",  {31'd0, busy},      32'd0);
    check_eq("mr_data",  {28'd0, out_data},  32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      check_eq("mr_after_valid", {31'd0, out_valid}, 32'd0);
    end

    // Idle between words, then a requester 1 word.
    req_valid = 2'b01;
    req_data0 = 16'h1234;
    #1;
    check_eq("id_grant0", {30'd0, req_ready}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      next_cycle();
      req_valid = 2'b00;
      #1;
      check_nibble("id_w0", 4'(4 - n), 1'b0, n == 0, n == 3);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      #1;
      check_eq("id_idle_valid", {31'd0, out_valid}, 32'd0);
      check_eq("id_idle_ready", {30'd0, req_ready}, 32'd0);
    end
    next_cycle();
    req_valid = 2'b10;
    req_data1 = 16'h0F0F;
    #1;
    check_eq("id_grant1", {30'd0, req_ready}, 32'd2);
    for (int n = 0; n < 4; n++) begin
      next_cycle();
      req_valid = 2'b00;
      req_data1 = 16'h0000;
      #1;
      check_nibble("id_w1", (n % 2 == 0) ? 4'hF : 4'h0, 1'b1, n == 0, n == 3);
    end
    next_cycle();
    #1;
    check_eq("id_end_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_ctrl.md
PISO_CTRL -- requirements
Module: piso_ctrl

Interface
REQ-001 SHALL have parameter NIB_W, default 4, meaning nibble width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning nibbles per word (word width NIB_W*DEPTH).
REQ-003 SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port req_valid  input  2  per-requester word valid, bit i = requester i.
REQ-006 SHALL have port req_data0  input  NIB_W*DEPTH  requester 0 word, nibble 0 in bits [NIB_W-1:0].
REQ-007 SHALL have port req_data1  input  NIB_W*DEPTH  requester 1 word, same layout.
REQ-008 SHALL have port req_ready  output  2  per-requester accept strobe, at most one bit high.
REQ-009 SHALL have port out_valid  output  1  serial nibble valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the nibble.
REQ-011 SHALL have port out_data  output  NIB_W  current serial nibble.
REQ-012 SHALL have port out_first  output  1  marks nibble 0 of a word.
REQ-013 SHALL have port out_last  output  1  marks nibble DEPTH-1 of a word.
REQ-014 SHALL have port out_id  output  1  requester index owning the current word.
REQ-015 SHALL have port busy  output  1  high whenever state is SHIFT.

Function
REQ-016 SHALL implement two states, IDLE and SHIFT, plus an internal DEPTH x NIB_W shift register, a nibble counter cnt (0..DEPTH-1) and a last_grant bit.
REQ-017 Load condition: (state==IDLE) or (state==SHIFT, cnt==DEPTH-1, out_valid & out_ready).
REQ-018 On the load condition with any req_valid set: grant one requester, assert its req_ready combinationally in that cycle, load its word, set cnt=0, set out_id=grant, enter or stay in SHIFT.
REQ-019 On the load condition with no req_valid set: enter IDLE; req_ready stays 0.
REQ-020 Arbitration: single valid wins; both valid -> requester != last_grant wins; last_grant updates only on a grant.
REQ-021 req_ready SHALL be 0 in all cycles other than the load condition.
REQ-022 out_valid SHALL equal (state==SHIFT); out_data SHALL be nibble 0 of the shift register.
REQ-023 On out_valid & out_ready with cnt<DEPTH-1: shift one nibble toward nibble 0 (zero fill), cnt+1.
REQ-024 out_valid & ~out_ready: shift register, cnt and out_id hold; out_data stable.
REQ-025 out_first = SHIFT & cnt==0; out_last = SHIFT & cnt==DEPTH-1.
REQ-026 Latency: word accepted in cycle T -> nibble 0 valid in T+1; with out_ready held high, nibble DEPTH-1 valid in T+DEPTH.
REQ-027 Back-to-back: a word pending at the last-nibble handshake SHALL produce nibble 0 in the next cycle, no bubble.
REQ-028 req_data/req_valid changes while not granted SHALL have no effect on the word in flight.

Reset
REQ-029 While reset==0 at a clk edge: state=IDLE, cnt=0, shift register=0, out_id=0, last_grant=1 (requester 0 wins first tie).
REQ-030 After reset: out_valid=0, out_first=0, out_last=0, busy=0, out_data=0, req_ready=0.
REQ-031 Reset mid-word SHALL discard the word; no further nibble of it is emitted.

Structure
REQ-032 State encoding (IDLE=0, SHIFT=1) and NIB_W/DEPTH defaults SHALL live in shared package piso_pkg.
REQ-033 Round-robin grant logic SHALL be sub-module piso_rr_arb (inputs req_valid, last_grant; output grant index, grant_valid).
REQ-034 Counter, shift register and FSM SHALL be inside piso_ctrl; no latches; all state on clk rising edge.

Verification
REQ-035 Reset, req0 valid data0=16'h4321, out_ready=1 -> req_ready=2'b01 in T; out_data 1,2,3,4 in T+1..T+4; first at 1, last at 4; out_id=0.
REQ-036 Both valid every cycle, data0=16'hAAAA, data1=16'h5555 -> words alternate id 0,1,0,1, each four nibbles, no idle cycle between words.
REQ-037 Word 16'h8765 with out_ready low for 3 cycles at cnt=1 -> out_data holds 6 for those cycles; sequence 5,6,7,8 completes unchanged.
REQ-038 reset=0 during cnt=2 of word 16'hFEDC -> next cycle out_valid=0, busy=0; no D or F follows.
REQ-039 No requests after a word ends -> IDLE, out_valid=0, req_ready=0; new req1 word 16'h0F0F -> nibbles F,0,F,0 with out_id=1.
REQ-040 Assertions: req_ready one-hot-or-zero; req_ready only under load condition; out_data stable while out_valid & ~out_ready.
